// File: rtl/output_vc_credit_ctrl.sv
// output_vc_credit_ctrl
//   Output-port flow controller for a NoC router. Tracks one credit counter
//   per virtual channel, mirroring the free slots of the neighbour's input
//   buffer. Each cycle it round-robin arbitrates among eligible VCs, pops one
//   flit from the winning local VC buffer and puts it on the link tagged with
//   its VC. With WORMHOLE_LOCK=1 the link stays on one VC from head to tail.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   empty      in   per-VC local buffer empty flag
//   tail       in   per-VC: flit at head of local buffer is a tail flit
//   credit_in  in   per-VC credit return pulse (one freed neighbour slot)
//   val        out  flit valid on link this cycle
//   vc_id      out  VC index of the flit on the link
//   read       out  one-hot pop strobe to local VC buffers
//   credit_err out  sticky: credit returned on a VC already at BUF_DEPTH
//
// Lock FSM
//   state     | meaning
//   ST_OPEN   | free round-robin arbitration among eligible VCs
//   ST_LOCKED | packet in flight on lock_vc_q; only that VC may be granted
module output_vc_credit_ctrl #(
    parameter int NUM_VC        = 4,
    parameter int BUF_DEPTH     = 4,
    parameter int WORMHOLE_LOCK = 1,
    localparam int CW           = $clog2(BUF_DEPTH + 1),
    localparam int VW           = $clog2(NUM_VC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_VC-1:0] empty,
    input  logic [NUM_VC-1:0] tail,
    input  logic [NUM_VC-1:0] credit_in,
    output logic              val,
    output logic [VW-1:0]     vc_id,
    output logic [NUM_VC-1:0] read,
    output logic              credit_err
);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t       state_q, state_d;
    logic [VW-1:0]     lock_vc_q, lock_vc_d;
    logic [VW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     credit_q [NUM_VC];
    logic [CW-1:0]     credit_d [NUM_VC];
    logic              credit_err_q, credit_err_d;

    logic [NUM_VC-1:0] elig;
    logic [NUM_VC-1:0] grant;
    logic [VW-1:0]     win_idx;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            elig[v] = !empty[v] && (credit_q[v] != '0);
        end
    end

    // Arbiter. Outputs are forced idle while reset is asserted, since the
    // inputs may already look eligible against the reset credit values.
    always_comb begin
        logic          found;
        logic [VW-1:0] idx;
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        if (state_q == ST_LOCKED) begin
            if (elig[lock_vc_q]) begin
                grant[lock_vc_q] = 1'b1;
                win_idx          = lock_vc_q;
            end
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                idx = VW'((int'(rr_ptr_q) + i) % NUM_VC);
                if (!found && elig[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    win_idx    = idx;
                end
            end
        end
        if (!rst_n) begin
            grant   = '0;
            win_idx = '0;
        end
    end

    assign val        = |grant;
    assign read       = grant;
    assign vc_id      = win_idx;
    assign credit_err = credit_err_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (val) begin
            rr_ptr_d = (win_idx == VW'(NUM_VC - 1)) ? '0 : win_idx + VW'(1);
        end
    end

    // Single-flit packets (head and tail together) never enter ST_LOCKED.
    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        case (state_q)
            ST_OPEN: begin
                if ((WORMHOLE_LOCK != 0) && val && !tail[win_idx]) begin
                    state_d   = ST_LOCKED;
                    lock_vc_d = win_idx;
                end
            end
            ST_LOCKED: begin
                if (val && tail[lock_vc_q]) begin
                    state_d = ST_OPEN;
                end
            end
            default: state_d = ST_OPEN;
        endcase
    end

    // A return on a full counter with no send is an upstream protocol error:
    // hold at BUF_DEPTH and flag it. A return with a send nets to zero.
    always_comb begin
        credit_err_d = credit_err_q;
        for (int v = 0; v < NUM_VC; v++) begin
            credit_d[v] = credit_q[v];
            if (read[v] && !credit_in[v]) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end else if (credit_in[v] && !read[v]) begin
                if (credit_q[v] == CW'(BUF_DEPTH)) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OPEN;
            lock_vc_q    <= '0;
            rr_ptr_q     <= '0;
            credit_err_q <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                credit_q[v] <= CW'(BUF_DEPTH);
            end
        end else begin
            state_q      <= state_d;
            lock_vc_q    <= lock_vc_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_err_q <= credit_err_d;
            for (int v = 0; v < NUM_VC; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

endmodule

// File: tb/tb_output_vc_credit_ctrl.sv
// Bench for output_vc_credit_ctrl. Two instances: dut_lk (WORMHOLE_LOCK=1)
// and dut_nl (WORMHOLE_LOCK=0), both NUM_VC=4, BUF_DEPTH=4. A vector table
// drives one instance per row (the other is held idle with all VCs empty);
// expected outputs go into a scoreboard queue and are popped and compared at
// the following falling edge.
module tb_output_vc_credit_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] empty0 = 4'hF, tail0 = 4'h0, cin0 = 4'h0;
    logic [3:0] empty1 = 4'hF, tail1 = 4'h0, cin1 = 4'h0;
    logic       val0, val1, err0, err1;
    logic [1:0] vc0, vc1;
    logic [3:0] rd0, rd1;

    always #5 clk = ~clk;

    output_vc_credit_ctrl #(.NUM_VC(4), .BUF_DEPTH(4), .WORMHOLE_LOCK(1)) dut_lk (
        .clk(clk), .rst_n(rst_n), .empty(empty0), .tail(tail0), .credit_in(cin0),
        .val(val0), .vc_id(vc0), .read(rd0), .credit_err(err0)
    );

    output_vc_credit_ctrl #(.NUM_VC(4), .BUF_DEPTH(4), .WORMHOLE_LOCK(0)) dut_nl (
        .clk(clk), .rst_n(rst_n), .empty(empty1), .tail(tail1), .credit_in(cin1),
        .val(val1), .vc_id(vc1), .read(rd1), .credit_err(err1)
    );

    typedef struct {
        bit         rst;
        bit         sel;
        logic [3:0] e;
        logic [3:0] t;
        logic [3:0] c;
        logic       ev;
        logic [1:0] evc;
        logic [3:0] erd;
        logic       eerr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(bit rst, bit sel, logic [3:0] e, logic [3:0] t, logic [3:0] c,
                                logic ev, logic [1:0] evc, logic [3:0] erd, logic eerr);
        vec_t v;
        v.rst = rst; v.sel = sel; v.e = e; v.t = t; v.c = c;
        v.ev = ev; v.evc = evc; v.erd = erd; v.eerr = eerr;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        empty0 = 4'hF; tail0 = 4'h0; cin0 = 4'h0;
        empty1 = 4'hF; tail1 = 4'h0; cin1 = 4'h0;
        #1;
        check("rst_lk_out", {val0, vc0, rd0, err0}, 8'h00);
        check("rst_nl_out", {val1, vc1, rd1, err1}, 8'h00);
        empty0 = 4'h0; empty1 = 4'h0;
        #1;
        check("rst_forced_idle", {val0, rd0, val1, rd1}, 10'h000);
        empty0 = 4'hF; empty1 = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply(vec_t v, int n);
        vec_t       x;
        logic [7:0] act;
        logic [7:0] exp;
        string      name;
        @(posedge clk);
        #1;
        if (!v.sel) begin
            empty0 = v.e; tail0 = v.t; cin0 = v.c;
            empty1 = 4'hF; tail1 = 4'h0; cin1 = 4'h0;
        end else begin
            empty1 = v.e; tail1 = v.t; cin1 = v.c;
            empty0 = 4'hF; tail0 = 4'h0; cin0 = 4'h0;
        end
        sb.push_back(v);
        @(negedge clk);
        x = sb.pop_front();
        if (!x.sel) act = {val0, (x.ev ? vc0 : 2'b00), rd0, err0};
        else        act = {val1, (x.ev ? vc1 : 2'b00), rd1, err1};
        exp = {x.ev, (x.ev ? x.evc : 2'b00), x.erd, x.eerr};
        name = $sformatf("vec%0d{val,vc,read,err}", n);
        check(name, {24'h0, act}, {24'h0, exp});
    endtask

    initial begin
        // VC0 alone drains its 4 credits, then stalls
        add(1, 0, 4'b1110, 4'b1111, 4'b0000, 1, 0, 4'b0001, 0);
        add(0, 0, 4'b1110, 4'b1111, 4'b0000, 1, 0, 4'b0001, 0);
        add(0, 0, 4'b1110, 4'b1111, 4'b0000, 1, 0, 4'b0001, 0);
        add(0, 0, 4'b1110, 4'b1111, 4'b0000, 1, 0, 4'b0001, 0);
        add(0, 0, 4'b1110, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0);
        add(0, 0, 4'b1110, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0);
        // credit return at t: stall at t, grant at t+1
        add(0, 0, 4'b1110, 4'b1111, 4'b0001, 0, 0, 4'b0000, 0);
        add(0, 0, 4'b1110, 4'b1111, 4'b0000, 1, 0, 4'b0001, 0);
        add(0, 0, 4'b1110, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0);
        // send + return same cycle keeps credit at 1
        add(0, 0, 4'b1110, 4'b1111, 4'b0001, 0, 0, 4'b0000, 0);
        add(0, 0, 4'b1110, 4'b1111, 4'b0001, 1, 0, 4'b0001, 0);
        add(0, 0, 4'b1110, 4'b1111, 4'b0000, 1, 0, 4'b0001, 0);
        add(0, 0, 4'b1110, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0);
        // refill VC0 to 4 without error
        for (int i = 0; i < 4; i++) add(0, 0, 4'b1111, 4'b1111, 4'b0001, 0, 0, 4'b0000, 0);
        add(0, 0, 4'b1111, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0);
        // overflow on VC2: saturate at 4, sticky error
        add(0, 0, 4'b1111, 4'b1111, 4'b0100, 0, 0, 4'b0000, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 4'b1011, 4'b1111, 4'b0000, 1, 2, 4'b0100, 1);
        add(0, 0, 4'b1011, 4'b1111, 4'b0000, 0, 0, 4'b0000, 1);
        // wormhole lock: VC1 head, VC1 bubbles do not let VC2 in
        add(1, 0, 4'b1001, 4'b0000, 4'b0000, 1, 1, 4'b0010, 0);
        add(0, 0, 4'b1011, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0);
        add(0, 0, 4'b1011, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0);
        add(0, 0, 4'b1001, 4'b0010, 4'b0000, 1, 1, 4'b0010, 0);
        add(0, 0, 4'b1011, 4'b0100, 4'b0000, 1, 2, 4'b0100, 0);
        add(0, 0, 4'b1011, 4'b0000, 4'b0000, 1, 2, 4'b0100, 0);
        // reset mid-packet (VC2 locked, rr_ptr=3): restarts OPEN at rr_ptr=0
        add(1, 0, 4'b0000, 4'b1111, 4'b0000, 1, 0, 4'b0001, 0);
        add(0, 0, 4'b1001, 4'b0000, 4'b0000, 1, 1, 4'b0010, 0);
        // no-lock instance: pure rotation, wrap 3->0, heads do not lock
        add(1, 1, 4'b0000, 4'b1111, 4'b0000, 1, 0, 4'b0001, 0);
        add(0, 1, 4'b0000, 4'b1111, 4'b0000, 1, 1, 4'b0010, 0);
        add(0, 1, 4'b0000, 4'b1111, 4'b0000, 1, 2, 4'b0100, 0);
        add(0, 1, 4'b0000, 4'b1111, 4'b0000, 1, 3, 4'b1000, 0);
        add(0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0001, 0);
        add(0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 1, 4'b0010, 0);
        add(0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 2, 4'b0100, 0);
        add(0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 3, 4'b1000, 0);

        for (int n = 0; n < vecs.size(); n++) begin
            if (vecs[n].rst) do_reset();
            apply(vecs[n], n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
